fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end; replaces the single Fetch/Decode pipeline register with a DEPTH-entry prefetch FIFO.
- Owns the fetch PC. Drives the combinational instruction memory. Presents {instr, pc, pc+4} to decode.
- Absorbs decode stalls without stalling fetch until the FIFO is full. Flushes on branch/jump redirect from Execute.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  Execute taken branch/jump (PCSrcE or jalr); flush and redirect.
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored, treated as 0.
- stall_d  input  1  decode stall; head is not consumed.
- imem_addr  output  XLEN  fetch address to instruction memory (combinational read).
- imem_rdata  input  XLEN  instruction word at imem_addr, same cycle.
- out_valid  output  1  head entry valid.
- out_instr  output  XLEN  head instruction.
- out_pc  output  XLEN  head PC.
- out_pc_plus4  output  XLEN  head PC + 4, modulo 2^XLEN.
- perf_flush_cnt  output  32  redirect count (optional feature).
- perf_full_cyc  output  32  cycles spent full with no dequeue (optional feature).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset (priority over everything):
  - pc_q = RESET_PC; count = 0; rd_ptr = wr_ptr = 0.
  - out_valid = 0; out_instr/out_pc/out_pc_plus4 = 0; perf counters = 0.
- Storage: circular buffer of DEPTH entries {instr, pc}.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- imem_addr = pc_q at all times.
- Dequeue:
  - deq = out_valid & ~stall_d & ~redirect_valid.
  - Head is registered FIFO content; outputs change only at the clock edge.
- Enqueue:
  - enq = ~redirect_valid & ((count < DEPTH) | deq).
  - On enq: write {imem_rdata, pc_q} at wr_ptr, then pc_q <= pc_q + 4 (wraps at 2^XLEN).
  - Simultaneous enq and deq at full: allowed; count unchanged; no bubble.
- Full and not dequeuing: no enqueue; pc_q holds; imem_addr stable.
- Empty: out_valid = 0; out_* hold last values (don't-care to consumer).
- Redirect (priority over stall_d and enqueue):
  - Next edge: count = 0, rd_ptr = wr_ptr, pc_q = {redirect_pc[XLEN-1:2], 2'b00}.
  - No entry is enqueued or dequeued in the redirect cycle.
  - out_valid is forced to 0 combinationally in the redirect cycle.
- Latency:
  - Reset deasserted at cycle t: out_valid = 1 with out_pc = RESET_PC in cycle t+1.
  - Redirect asserted in cycle t: target fetched in cycle t+1; out_valid with out_pc = target in cycle t+2.
  - Redirect asserted again in cycle t+1: the second target wins.
- Steady state: with stall_d = 0 and no redirect, one instruction per cycle, in program order, PCs consecutive +4.
- Stall then release:
  - FIFO fills to DEPTH, then fetch pauses.
  - On release, entries drain in order.
  - Fetch resumes the same cycle as the first dequeue, with no PC gap.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined:
  - perf_flush_cnt increments on every cycle with redirect_valid = 1.
  - perf_full_cyc increments on every cycle with count == DEPTH & ~deq & ~redirect_valid.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by rst.
- Undefined: both ports tied to 0; no counter flops synthesised.

Test Plan:
- Reset release, stall_d = 0, imem holds word = addr ^ 32'hA5A5_0000 -> out_valid from cycle 1; out_pc = 0,4,8,...; out_instr matches; out_pc_plus4 = out_pc + 4.
- Stall_d held 10 cycles with DEPTH = 4 -> count saturates at 4; imem_addr holds 0x10; release -> out_pc 0,4,8,0xC then 0x10 back-to-back, no bubble; perf_full_cyc = 6 with macro.
- Redirect_valid pulse with redirect_pc = 0x0000_0103 while queue holds 3 entries -> out_valid = 0 that cycle and the next; then out_pc = 0x100, 0x104; perf_flush_cnt = 1 with macro.
- Redirect concurrent with stall_d = 1 and full queue -> flush wins; first output is the target 2 cycles later.
- Back-to-back redirects to 0x40 then 0x80 -> no 0x40 entry ever valid; first valid out_pc = 0x80.
- rst asserted mid-stream with queue full -> next cycle out_valid = 0, imem_addr = RESET_PC; stream restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO.
// Owns the fetch PC, drives a combinational instruction memory, and presents
// {instr, pc, pc+4} of the FIFO head to decode. Redirects from Execute flush
// the queue and restart fetch at the target.
// Optional performance counters are built when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_full_cyc
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [AW:0]     r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [XLEN-1:0] r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [XLEN-1:0] r_head_instr;
  logic [XLEN-1:0] r_head_pc;
  logic [XLEN-1:0] r_head_pc4;

  logic            w_full;
  logic            w_out_valid;
  logic            w_deq;
  logic            w_enq;
  logic [XLEN-1:0] w_redirect_pc;
  logic [AW:0]     w_count_after_deq;
  logic [AW-1:0]   w_rd_ptr_nxt;
  logic [XLEN-1:0] w_head_instr_nxt;
  logic [XLEN-1:0] w_head_pc_nxt;
  logic            w_unused;

  // The low redirect bits are ignored: fetch addresses are word aligned.
  assign w_unused          = ^redirect_pc[1:0];
  assign w_redirect_pc     = {redirect_pc[XLEN-1:2], 2'b00};

  assign w_full            = (r_count == (AW+1)'(DEPTH));
  assign w_out_valid       = (r_count != '0) & ~redirect_valid;
  assign w_deq             = w_out_valid & ~stall_d;
  assign w_enq             = ~redirect_valid & (~w_full | w_deq);
  assign w_count_after_deq = r_count - {{AW{1'b0}}, w_deq};
  assign w_rd_ptr_nxt      = r_rd_ptr + {{(AW-1){1'b0}}, w_deq};

  assign imem_addr         = r_pc;
  assign out_valid         = w_out_valid;
  assign out_instr         = r_head_instr;
  assign out_pc            = r_head_pc;
  assign out_pc_plus4      = r_head_pc4;

  // Select what the head registers show after this edge: the word being
  // fetched now if the queue would otherwise be empty, else the stored entry.
  always_comb begin
    // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
    w_head_instr_nxt = r_head_instr;
    w_head_pc_nxt    = r_head_pc;
    if (!redirect_valid) begin
      if (w_count_after_deq == '0) begin
        if (w_enq) begin
          w_head_instr_nxt = imem_rdata;
          w_head_pc_nxt    = r_pc;
        end
      end else begin
        w_head_instr_nxt = r_mem_instr[w_rd_ptr_nxt];
        w_head_pc_nxt    = r_mem_pc[w_rd_ptr_nxt];
      end
    end
  end

  // Fetch PC, pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_pc         <= RESET_PC;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_head_pc4   <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_pc;
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_after_deq + {{AW{1'b0}}, w_enq};
      r_head_instr <= w_head_instr_nxt;
      r_head_pc    <= w_head_pc_nxt;
      r_head_pc4   <= w_head_pc_nxt + XLEN'(4);
      if (w_enq) begin
        r_pc     <= r_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count and pointers define which entries are live.
    if (!rst && w_enq) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_pc;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_flush_cnt;
  logic [31:0] r_full_cyc;

  // Saturating redirect and full-stall cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= '0;
      r_full_cyc  <= '0;
    end else begin
      if (redirect_valid && r_flush_cnt != 32'hFFFF_FFFF)
        r_flush_cnt <= r_flush_cnt + 32'd1;
      if (w_full && !w_deq && !redirect_valid && r_full_cyc != 32'hFFFF_FFFF)
        r_full_cyc <= r_full_cyc + 32'd1;
    end
  end

  assign perf_flush_cnt = r_flush_cnt;
  assign perf_full_cyc  = r_full_cyc;
`else
  assign perf_flush_cnt = '0;
  assign perf_full_cyc  = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH = 4, RESET_PC = 0).
// Instruction memory model: word = addr ^ 32'hA5A5_0000.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_full_cyc;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_full_cyc  (perf_full_cyc)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"},    out_pc,             pc);
    check({tag, ".instr"}, out_instr,          pc ^ 32'hA5A5_0000);
    check({tag, ".pc4"},   out_pc_plus4,       p4);
  endtask

  // Advance one clock; inputs are then applied 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after new inputs, before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
    cyc(); cyc();

    // Reset state
    settle();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.pc",    out_pc,             32'd0);
    check("rst.instr", out_instr,          32'd0);
    check("rst.pc4",   out_pc_plus4,       32'd0);
    check("rst.imem",  imem_addr,          32'd0);
    check("rst.flush", perf_flush_cnt,     32'd0);
    check("rst.full",  perf_full_cyc,      32'd0);

    // Streaming from reset: valid one cycle after release
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 6; k++) begin
      settle();
      expect_head("stream", 32'(k * 4));
      cyc();
    end

    // Stall 10 cycles: fills to 4, fetch pauses at 0x10, then drains in order
    rst = 1'b1; cyc();
    rst = 1'b0; stall_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (i >= 4) check("stall.imem", imem_addr, 32'h10);
      cyc();
    end
    stall_d = 1'b0;
    settle();
`ifdef FETCH_QUEUE_PERF_EN
    check("stall.perf_full", perf_full_cyc, 32'd6);
`else
    check("stall.perf_full", perf_full_cyc, 32'd0);
`endif
    for (int k = 0; k < 6; k++) begin
      settle();
      expect_head("drain", 32'(k * 4));
      cyc();
    end

    // Redirect with 3 entries queued
    rst = 1'b1; cyc();
    rst = 1'b0; stall_d = 1'b1;
    cyc(); cyc(); cyc();
    stall_d = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    settle();
    check("redir.valid0", {31'd0, out_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    settle();
    check("redir.valid1", {31'd0, out_valid}, 32'd0);
    check("redir.imem",   imem_addr,          32'h100);
`ifdef FETCH_QUEUE_PERF_EN
    check("redir.perf_flush", perf_flush_cnt, 32'd1);
`else
    check("redir.perf_flush", perf_flush_cnt, 32'd0);
`endif
    cyc(); settle(); expect_head("redir.t0", 32'h100);
    cyc(); settle(); expect_head("redir.t1", 32'h104);

    // Redirect concurrent with stall on a full queue
    stall_d = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    settle();
    check("fullredir.pre", {31'd0, out_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle();
    check("fullredir.valid0", {31'd0, out_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0; stall_d = 1'b0;
    settle();
    check("fullredir.valid1", {31'd0, out_valid}, 32'd0);
    cyc(); settle(); expect_head("fullredir.t0", 32'h200);

    // Back-to-back redirects: the second target wins
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    settle();
    check("b2b.valid0", {31'd0, out_valid}, 32'd0);
    cyc();
    redirect_pc = 32'h80;
    settle();
    check("b2b.valid1", {31'd0, out_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    settle();
    check("b2b.valid2", {31'd0, out_valid}, 32'd0);
    check("b2b.imem",   imem_addr,          32'h80);
    cyc(); settle(); expect_head("b2b.t0", 32'h80);
    cyc(); settle(); expect_head("b2b.t1", 32'h84);

    // PC wraps at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cyc();
    redirect_valid = 1'b0;
    cyc(); settle(); expect_head("wrap.t0", 32'hFFFF_FFFC);
    cyc(); settle(); expect_head("wrap.t1", 32'h0);

    // Reset mid-stream with a full queue
    stall_d = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    settle();
    check("midrst.pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; stall_d = 1'b0;
    settle();
    check("midrst.valid", {31'd0, out_valid}, 32'd0);
    check("midrst.imem",  imem_addr,          32'd0);
    check("midrst.pc",    out_pc,             32'd0);
    cyc(); settle(); expect_head("midrst.t0", 32'h0);
    cyc(); settle(); expect_head("midrst.t1", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
